// File: rtl/case_seq_pkg.sv
// Shared encodings and helpers for the case-driven delay sequencer.
// Optional abort-on-change behaviour: CASE_SEQ_ABORT_ON_CHANGE_EN.
package case_seq_pkg;

    localparam logic [1:0] SAMPLE = 2'd0;
    localparam logic [1:0] PRE    = 2'd1;
    localparam logic [1:0] POST   = 2'd2;
    localparam logic [1:0] DFLT   = 2'd3;

    // Width able to hold max(a,b,c)-1, never narrower than one bit.
    function automatic int cnt_width(
        input int a,
        input int b,
        input int c
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/case_seq_counter.sv
// Loadable down-counter with zero flag; reused for every wait phase.
// Stops at zero; it is always reloaded before the next use.
module case_seq_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/case_delay_sequencer.sv
// Samples a selector, waits PRE, drives the case value, holds POST.
// Optional abort-on-change in PRE: CASE_SEQ_ABORT_ON_CHANGE_EN.
module case_delay_sequencer
    import case_seq_pkg::*;
#(
    parameter int WIDTH          = 4,
    parameter int NUM_CASES      = 3,
    parameter int PRE_CYCLES     = 3,
    parameter int POST_CYCLES    = 3,
    parameter int DEFAULT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] sel,
    output logic [WIDTH-1:0] value_out,
    output logic             upd,
    output logic             busy,
    output logic             miss
);

    localparam int CW = cnt_width(PRE_CYCLES, POST_CYCLES, DEFAULT_CYCLES);

    if (PRE_CYCLES < 1 || POST_CYCLES < 1 || DEFAULT_CYCLES < 1)
    begin : g_bad_cycles
        $error("case_delay_sequencer: cycle parameters must be >= 1");
    end

    if (NUM_CASES < 1 || NUM_CASES > (1 << WIDTH)) begin : g_bad_cases
        $error("case_delay_sequencer: NUM_CASES out of range");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [WIDTH-1:0] r_sel_q;
    logic [WIDTH-1:0] r_value;
    logic             r_upd;
    logic             r_miss;

    logic             w_match;
    logic             w_abort;
    logic             w_zero;
    logic             w_load;
    logic [CW-1:0]    w_load_val;
    logic             w_dec;
    logic             w_cap;
    logic             w_do_upd;
    logic             w_do_miss;

    // Extra bit so NUM_CASES == 2**WIDTH still compares correctly.
    assign w_match = ({1'b0, sel} < (WIDTH+1)'(NUM_CASES));

`ifdef CASE_SEQ_ABORT_ON_CHANGE_EN
    assign w_abort = (sel != r_sel_q);
`else
    assign w_abort = 1'b0;
`endif

    case_seq_counter #(
        .W (CW)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SAMPLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SAMPLE: begin
                if (en) w_next = w_match ? PRE : DFLT;
            end
            PRE: begin
                if (w_zero)       w_next = POST;
                else if (w_abort) w_next = SAMPLE;
            end
            POST: begin
                if (w_zero) w_next = SAMPLE;
            end
            DFLT: begin
                if (w_zero) w_next = SAMPLE;
            end
            default: w_next = SAMPLE;
        endcase
    end

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        w_dec      = 1'b0;
        w_cap      = 1'b0;
        w_do_upd   = 1'b0;
        w_do_miss  = 1'b0;
        unique case (r_state)
            SAMPLE: begin
                if (en) begin
                    w_cap  = 1'b1;
                    w_load = 1'b1;
                    if (w_match) begin
                        w_load_val = CW'(PRE_CYCLES - 1);
                    end else begin
                        w_load_val = CW'(DEFAULT_CYCLES - 1);
                        w_do_miss  = 1'b1;
                    end
                end
            end
            PRE: begin
                if (w_zero) begin
                    w_do_upd   = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = CW'(POST_CYCLES - 1);
                end else begin
                    w_dec = 1'b1;
                end
            end
            POST, DFLT: begin
                w_dec = 1'b1;
            end
            default: begin
                w_dec = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q <= '0;
            r_value <= '0;
            r_upd   <= 1'b0;
            r_miss  <= 1'b0;
        end else begin
            if (w_cap)    r_sel_q <= sel;
            if (w_do_upd) r_value <= r_sel_q;
            r_upd  <= w_do_upd;
            r_miss <= w_do_miss;
        end
    end

    assign value_out = r_value;
    assign upd       = r_upd;
    assign miss      = r_miss;
    assign busy      = (r_state != SAMPLE);

endmodule

// File: tb/tb_case_delay_sequencer.sv
// Scoreboard bench for case_delay_sequencer (default parameters).
// Build with CASE_SEQ_ABORT_ON_CHANGE_EN to check the abort variant.
module tb_case_delay_sequencer;

    localparam int W    = 4;
    localparam int NC   = 3;
    localparam int PRE  = 3;
    localparam int POST = 3;
    localparam int DEF  = 2;

    typedef struct {
        int         due;
        bit         is_miss;
        logic [W-1:0] val;
    } ev_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] sel;
    logic [W-1:0] value_out;
    logic         upd;
    logic         busy;
    logic         miss;

    int           n_checks = 0;
    int           n_fail   = 0;

    ev_t          q[$];
    int           edge_n     = 0;
    int           busy_until = -1;
    int           next_free  = 0;
    logic [W-1:0] exp_val    = '0;
`ifdef CASE_SEQ_ABORT_ON_CHANGE_EN
    logic [W-1:0] samp   = '0;
    int           pre_lo = 1;
    int           pre_hi = 0;
`endif

    case_delay_sequencer #(
        .WIDTH          (W),
        .NUM_CASES      (NC),
        .PRE_CYCLES     (PRE),
        .POST_CYCLES    (POST),
        .DEFAULT_CYCLES (DEF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sel       (sel),
        .value_out (value_out),
        .upd       (upd),
        .busy      (busy),
        .miss      (miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h expected %0h",
                     tag, edge_n, got, exp);
        end
    endtask

    // Reference timeline: each sample schedules its visible events.
    always @(posedge clk) begin
        edge_n++;
        if (!rst_n) begin
            q.delete();
            busy_until = -1;
            next_free  = 0;
`ifdef CASE_SEQ_ABORT_ON_CHANGE_EN
            pre_hi = 0;
`endif
        end else begin
`ifdef CASE_SEQ_ABORT_ON_CHANGE_EN
            if (edge_n >= pre_lo && edge_n <= pre_hi && sel != samp) begin
                void'(q.pop_back());
                busy_until = edge_n - 1;
                next_free  = edge_n + 1;
                pre_hi     = 0;
            end
`endif
            if (edge_n >= next_free && en) begin
                if (int'(sel) < NC) begin
                    q.push_back('{due: edge_n + PRE, is_miss: 1'b0,
                                  val: sel});
                    busy_until = edge_n + PRE + POST - 1;
                    next_free  = edge_n + PRE + POST + 1;
`ifdef CASE_SEQ_ABORT_ON_CHANGE_EN
                    samp   = sel;
                    pre_lo = edge_n + 1;
                    pre_hi = edge_n + PRE - 1;
`endif
                end else begin
                    q.push_back('{due: edge_n, is_miss: 1'b1, val: '0});
                    busy_until = edge_n + DEF - 1;
                    next_free  = edge_n + DEF + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_upd;
        logic e_miss;
        if (!rst_n) begin
            exp_val = '0;
            check("rst_value", value_out, 0);
            check("rst_busy",  busy, 0);
            check("rst_upd",   upd, 0);
            check("rst_miss",  miss, 0);
        end else begin
            e_upd  = 1'b0;
            e_miss = 1'b0;
            if (q.size() > 0 && q[0].due == edge_n) begin
                if (q[0].is_miss) begin
                    e_miss = 1'b1;
                end else begin
                    e_upd   = 1'b1;
                    exp_val = q[0].val;
                end
                void'(q.pop_front());
            end
            check("upd",   upd, e_upd);
            check("miss",  miss, e_miss);
            check("value", value_out, exp_val);
            check("busy",  busy, edge_n <= busy_until);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = busy;
        end
        check("busy_wait", seen, 1);
    endtask

    task automatic wait_upd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = upd;
        end
        check("upd_wait", seen, 1);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        sel   = '0;
        cycles(2);
        rst_n = 1'b1;
        cycles(10);

        sel = 4'b0001;
        cycles(16);

        sel = 4'b0101;
        cycles(8);

        en = 1'b0;
        cycles(10);
        sel = 4'd0;
        en  = 1'b1;
        wait_busy();
        sel = 4'd2;
        cycles(20);

        wait_upd();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy",  busy, 0);
        check("async_value", value_out, 0);
        cycles(2);
        en    = 1'b0;
        rst_n = 1'b1;
        cycles(20);
        check("idle_busy", busy, 0);

        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) sel = W'($urandom_range(0, 5));
            en = ($urandom_range(0, 4) != 0);
        end

        @(negedge clk);
        en = 1'b0;
        cycles(12);
        check("drain", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
